// File: rtl/n2_btb_if.sv
// Prediction/update bundle between the fetch/execute stages and the branch target buffer.
// The master side issues lookups and updates; the slave side owns the table and returns
// the registered prediction record.
interface n2_btb_if #(
  parameter int ENTRIES = 8
) ();
  localparam int IDX_W = $clog2(ENTRIES);

  logic             flush_i;
  logic             lookup_v_i;
  logic [31:0]      lookup_pc_i;
  logic             btb_hit_o;
  logic             btb_jump_o;
  logic [31:0]      btb_tgt_o;
  logic [31:0]      btb_pc_o;
  logic [IDX_W-1:0] btb_entry_o;
  logic             upd_v_i;
  logic             upd_insert_i;
  logic             upd_bht_i;
  logic             upd_inc_i;
  logic             upd_tgt_v_i;
  logic [31:0]      upd_pc_i;
  logic [31:0]      upd_tgt_i;
  logic [IDX_W-1:0] upd_entry_i;

  modport master (
    output flush_i, lookup_v_i, lookup_pc_i,
    output upd_v_i, upd_insert_i, upd_bht_i, upd_inc_i, upd_tgt_v_i,
    output upd_pc_i, upd_tgt_i, upd_entry_i,
    input  btb_hit_o, btb_jump_o, btb_tgt_o, btb_pc_o, btb_entry_o
  );

  modport slave (
    input  flush_i, lookup_v_i, lookup_pc_i,
    input  upd_v_i, upd_insert_i, upd_bht_i, upd_inc_i, upd_tgt_v_i,
    input  upd_pc_i, upd_tgt_i, upd_entry_i,
    output btb_hit_o, btb_jump_o, btb_tgt_o, btb_pc_o, btb_entry_o
  );
endinterface

// File: rtl/n2_btb.sv
// Fully associative branch target buffer with a 2-bit bimodal counter per entry.
// Lookups return a registered prediction record one cycle later; updates from execute
// allocate entries round-robin (deduplicated by PC) or train/retarget an existing entry,
// guarded by a tag check so updates aimed at an evicted entry are dropped.
module n2_btb #(
  parameter int ENTRIES = 8
) (
  input logic         clk,
  input logic         resetn,
  n2_btb_if.slave     bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [31:0]        tag  [ENTRIES];
  logic [31:0]        tgt  [ENTRIES];
  logic [1:0]         ctr  [ENTRIES];
  logic [IDX_W-1:0]   rr;

  logic               lk_hit;
  logic [IDX_W-1:0]   lk_idx;
  logic               ins_hit;
  logic [IDX_W-1:0]   ins_idx;
  logic               upd_ok;

  // Saturating 2-bit counter step; holds at 0 and 3.
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic inc);
    if (inc) return (c == 2'b11) ? c : c + 2'b01;
    else     return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Associative tag match for the lookup PC and for the insert PC (dedup).
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    ins_hit = 1'b0;
    ins_idx = rr;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == bus.lookup_pc_i) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid[i] && tag[i] == bus.upd_pc_i) begin
        ins_hit = 1'b1;
        ins_idx = IDX_W'(i);
      end
    end
  end

  // Train/retarget only if the addressed entry still belongs to this branch.
  assign upd_ok = valid[bus.upd_entry_i] && (tag[bus.upd_entry_i] == bus.upd_pc_i);

  // Prediction record register and table state; lookups see pre-update state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid           <= '0;
      rr              <= '0;
      bus.btb_hit_o   <= 1'b0;
      bus.btb_jump_o  <= 1'b0;
      bus.btb_tgt_o   <= '0;
      bus.btb_pc_o    <= '0;
      bus.btb_entry_o <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        tgt[i] <= '0;
        ctr[i] <= 2'b01;
      end
    end else begin
      if (bus.lookup_v_i) begin
        bus.btb_hit_o   <= lk_hit;
        bus.btb_jump_o  <= lk_hit & ctr[lk_idx][1];
        bus.btb_tgt_o   <= lk_hit ? tgt[lk_idx] : 32'h0;
        bus.btb_pc_o    <= bus.lookup_pc_i;
        bus.btb_entry_o <= lk_hit ? lk_idx : rr;
      end
      if (bus.flush_i) begin
        valid <= '0;
        rr    <= '0;
      end else if (bus.upd_v_i) begin
        if (bus.upd_insert_i) begin
          valid[ins_idx] <= 1'b1;
          tag[ins_idx]   <= bus.upd_pc_i;
          tgt[ins_idx]   <= bus.upd_tgt_i;
          ctr[ins_idx]   <= bus.upd_inc_i ? 2'b10 : 2'b01;
          if (!ins_hit) rr <= rr + IDX_W'(1);
        end else begin
          if (bus.upd_bht_i && upd_ok)
            ctr[bus.upd_entry_i] <= ctr_train(ctr[bus.upd_entry_i], bus.upd_inc_i);
          if (bus.upd_tgt_v_i && upd_ok)
            tgt[bus.upd_entry_i] <= bus.upd_tgt_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_n2_btb.sv
// Directed plus randomized bench for n2_btb against a behavioural table model.
module tb_n2_btb;
  localparam int ENTRIES = 8;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  n2_btb_if #(.ENTRIES(ENTRIES)) bus ();
  n2_btb #(.ENTRIES(ENTRIES)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  // Reference model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_rr;
  bit          e_hit, e_jump;
  int unsigned e_tgt, e_pc;
  int          e_entry;

  int nvec  = 0;
  int nfail = 0;

  function automatic int find(input int unsigned pc);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_rr = 0;
    e_hit = 0; e_jump = 0; e_tgt = 0; e_pc = 0; e_entry = 0;
  endtask

  task automatic model_step();
    int k, e;
    if (bus.lookup_v_i) begin
      k = find(bus.lookup_pc_i);
      e_pc = bus.lookup_pc_i;
      if (k >= 0) begin
        e_hit = 1; e_jump = (m_ctr[k] >= 2); e_tgt = m_tgt[k]; e_entry = k;
      end else begin
        e_hit = 0; e_jump = 0; e_tgt = 0; e_entry = m_rr;
      end
    end
    if (bus.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_rr = 0;
    end else if (bus.upd_v_i) begin
      if (bus.upd_insert_i) begin
        k = find(bus.upd_pc_i);
        if (k < 0) begin
          k = m_rr;
          m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[k] = 1; m_tag[k] = bus.upd_pc_i; m_tgt[k] = bus.upd_tgt_i;
        m_ctr[k] = bus.upd_inc_i ? 2 : 1;
      end else begin
        e = int'(bus.upd_entry_i);
        if (m_valid[e] && m_tag[e] == bus.upd_pc_i) begin
          if (bus.upd_bht_i) begin
            if (bus.upd_inc_i) m_ctr[e] = (m_ctr[e] == 3) ? 3 : m_ctr[e] + 1;
            else               m_ctr[e] = (m_ctr[e] == 0) ? 0 : m_ctr[e] - 1;
          end
          if (bus.upd_tgt_v_i) m_tgt[e] = bus.upd_tgt_i;
        end
      end
    end
  endtask

  task automatic check(input string name);
    logic [IDX_W-1:0] ee;
    ee = IDX_W'(e_entry);
    nvec++;
    assert (bus.btb_hit_o === e_hit && bus.btb_jump_o === e_jump &&
            bus.btb_tgt_o === e_tgt && bus.btb_pc_o === e_pc && bus.btb_entry_o === ee)
    else begin
      nfail++;
      $error("FAIL %s: got hit=%0b jump=%0b tgt=%h pc=%h entry=%0d, expected hit=%0b jump=%0b tgt=%h pc=%h entry=%0d",
             name, bus.btb_hit_o, bus.btb_jump_o, bus.btb_tgt_o, bus.btb_pc_o, bus.btb_entry_o,
             e_hit, e_jump, e_tgt, e_pc, ee);
    end
  endtask

  task automatic idle();
    bus.flush_i = 0; bus.lookup_v_i = 0; bus.lookup_pc_i = 0;
    bus.upd_v_i = 0; bus.upd_insert_i = 0; bus.upd_bht_i = 0; bus.upd_inc_i = 0;
    bus.upd_tgt_v_i = 0; bus.upd_pc_i = 0; bus.upd_tgt_i = 0; bus.upd_entry_i = '0;
  endtask

  // One clock: model consumes the same inputs the DUT saw at the edge, then compare.
  task automatic cycle(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name);
    idle();
  endtask

  task automatic lookup(input int unsigned pc, input string name);
    bus.lookup_v_i = 1; bus.lookup_pc_i = pc;
    cycle(name);
  endtask

  task automatic insert(input int unsigned pc, input int unsigned t, input bit inc);
    bus.upd_v_i = 1; bus.upd_insert_i = 1; bus.upd_pc_i = pc; bus.upd_tgt_i = t; bus.upd_inc_i = inc;
  endtask

  task automatic train(input int e, input int unsigned pc, input bit inc);
    bus.upd_v_i = 1; bus.upd_bht_i = 1; bus.upd_entry_i = IDX_W'(e); bus.upd_pc_i = pc; bus.upd_inc_i = inc;
  endtask

  initial begin
    int k;
    idle();
    model_reset();
    #2;
    check("reset_state");
    #20;
    @(posedge clk); #1;
    resetn = 1;

    // Cold lookup misses at entry 0
    lookup(32'h100, "cold_miss");

    // Insert then hit; rr advanced to 1
    insert(32'h100, 32'h140, 1); cycle("insert_100");
    lookup(32'h100, "hit_100");
    lookup(32'h104, "miss_rr1");

    // Counter training down to 0 then saturating at 3
    train(0, 32'h100, 0); cycle("nt1");
    train(0, 32'h100, 0); cycle("nt2");
    lookup(32'h100, "ctr0_jump");
    train(0, 32'h100, 0); cycle("nt_sat0");
    for (int i = 0; i < 4; i++) begin
      train(0, 32'h100, 1); cycle("taken");
    end
    lookup(32'h100, "ctr3_jump");
    train(0, 32'h100, 0); cycle("nt_after_sat");
    lookup(32'h100, "ctr2_jump");

    // Target rewrite together with a train
    train(0, 32'h100, 0); bus.upd_tgt_v_i = 1; bus.upd_tgt_i = 32'h180; cycle("retarget");
    lookup(32'h100, "retarget_hit");

    // upd_v_i low: table untouched
    bus.upd_insert_i = 1; bus.upd_pc_i = 32'h500; bus.upd_tgt_i = 32'h1; cycle("upd_v_low");
    lookup(32'h500, "upd_v_low_miss");

    // Flush with simultaneous insert; flush wins, rr back to 0
    bus.flush_i = 1; insert(32'h600, 32'h640, 1); cycle("flush_ins");
    lookup(32'h100, "post_flush_100");
    lookup(32'h600, "post_flush_600");

    // Nine inserts wrap rr and evict entry 0
    for (int i = 0; i < 9; i++) begin
      insert(32'(i * 4), 32'h1000 + 32'(i * 4), 1); cycle("wrap_ins");
    end
    lookup(32'h0, "evicted_0");
    lookup(32'h20, "wrapped_20");
    insert(32'h8, 32'h2000, 0); cycle("reinsert_8");
    lookup(32'h8, "reinsert_8_hit");
    lookup(32'h300, "rr_unchanged");

    // Same-cycle insert and lookup: no bypass
    insert(32'h200, 32'h240, 1); bus.lookup_v_i = 1; bus.lookup_pc_i = 32'h200; cycle("same_cycle");
    lookup(32'h200, "next_cycle_hit");

    // Stale train on evicted entry 0 is dropped
    train(0, 32'h0, 0); cycle("stale_train");
    train(0, 32'h0, 0); cycle("stale_train2");
    lookup(32'h20, "stale_unchanged");

    // Randomized traffic over a PC pool larger than the table
    for (int n = 0; n < 400; n++) begin
      bus.lookup_v_i  = ($urandom_range(0, 3) != 0);
      bus.lookup_pc_i = 32'h4000 + 32'($urandom_range(0, 11) * 4);
      bus.upd_v_i     = $urandom_range(0, 1);
      bus.upd_insert_i = ($urandom_range(0, 2) == 0);
      bus.upd_bht_i   = $urandom_range(0, 1);
      bus.upd_tgt_v_i = ($urandom_range(0, 3) == 0);
      bus.upd_inc_i   = $urandom_range(0, 1);
      bus.upd_pc_i    = 32'h4000 + 32'($urandom_range(0, 11) * 4);
      bus.upd_tgt_i   = $urandom;
      k = find(bus.upd_pc_i);
      bus.upd_entry_i = (k >= 0 && $urandom_range(0, 3) != 0) ? IDX_W'(k) : IDX_W'($urandom_range(0, ENTRIES - 1));
      bus.flush_i     = ($urandom_range(0, 60) == 0);
      cycle("random");
    end

    // Asynchronous reset mid-stream
    lookup(32'h4000, "pre_reset");
    #3;
    resetn = 0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge clk); #1;
    check("reset_held");
    resetn = 1;
    lookup(32'h4000, "first_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
